// File: rtl/mem_stage.sv
// Memory pipeline stage: passes ALU results to write-back, or holds the pipe
// while a single load/store is outstanding on the data-memory handshake.
module mem_stage #(
    parameter int TIMEOUT = 15
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        RW,
    input  logic [4:0]  DA,
    input  logic [1:0]  MD,
    input  logic        MW,
    input  logic [31:0] F,
    input  logic [31:0] B_DATA,
    input  logic        V,
    input  logic        N,
    output logic        RW_out,
    output logic [4:0]  DA_out,
    output logic [1:0]  MD_out,
    output logic [31:0] F_out,
    output logic [31:0] Data_out,
    output logic        VxorN_out,
    output logic        MEM_REQ,
    output logic        MEM_WE,
    output logic [31:0] MEM_ADDR,
    output logic [31:0] MEM_WDATA,
    input  logic [31:0] MEM_RDATA,
    input  logic        MEM_ACK,
    output logic        STALL,
    output logic        ERR
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t      r_state, r_state_next;
    logic [7:0]  r_cnt, r_cnt_next;
    logic        r_err, r_err_next;
    logic        r_req, r_req_next;
    logic        r_we, r_we_next;
    logic [31:0] r_addr, r_addr_next;
    logic [31:0] r_wdata, r_wdata_next;
    logic        r_cap_rw, r_cap_rw_next;
    logic [4:0]  r_cap_da, r_cap_da_next;
    logic [1:0]  r_cap_md, r_cap_md_next;
    logic        r_cap_vxn, r_cap_vxn_next;
    logic        r_rw_out, r_rw_out_next;
    logic [4:0]  r_da_out, r_da_out_next;
    logic [1:0]  r_md_out, r_md_out_next;
    logic [31:0] r_f_out, r_f_out_next;
    logic [31:0] r_data_out, r_data_out_next;
    logic        r_vxn_out, r_vxn_out_next;

    logic        w_mem_op;
    logic        w_vxn;
    logic        w_is_load;
    logic [7:0]  w_cnt_inc;
    logic        w_timeout;

    assign w_mem_op  = (MD == 2'd1) || MW;
    assign w_vxn     = V ^ N;
    // A store wins over a simultaneous load request, so only a pure load returns data.
    assign w_is_load = (r_cap_md == 2'd1) && !r_we;
    assign w_cnt_inc = r_cnt + 8'd1;
    assign w_timeout = (w_cnt_inc == TIMEOUT_CNT);

    always_ff @(negedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            r_state    <= S_IDLE;
            r_cnt      <= 8'd0;
            r_err      <= 1'b0;
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_cap_rw   <= 1'b0;
            r_cap_da   <= 5'd0;
            r_cap_md   <= 2'd0;
            r_cap_vxn  <= 1'b0;
            r_rw_out   <= 1'b0;
            r_da_out   <= 5'd0;
            r_md_out   <= 2'd0;
            r_f_out    <= 32'd0;
            r_data_out <= 32'd0;
            r_vxn_out  <= 1'b0;
        end else begin
            r_state    <= r_state_next;
            r_cnt      <= r_cnt_next;
            r_err      <= r_err_next;
            r_req      <= r_req_next;
            r_we       <= r_we_next;
            r_addr     <= r_addr_next;
            r_wdata    <= r_wdata_next;
            r_cap_rw   <= r_cap_rw_next;
            r_cap_da   <= r_cap_da_next;
            r_cap_md   <= r_cap_md_next;
            r_cap_vxn  <= r_cap_vxn_next;
            r_rw_out   <= r_rw_out_next;
            r_da_out   <= r_da_out_next;
            r_md_out   <= r_md_out_next;
            r_f_out    <= r_f_out_next;
            r_data_out <= r_data_out_next;
            r_vxn_out  <= r_vxn_out_next;
        end
    end

    always_comb begin
        r_state_next    = r_state;
        r_cnt_next      = r_cnt;
        r_err_next      = r_err;
        r_req_next      = r_req;
        r_we_next       = r_we;
        r_addr_next     = r_addr;
        r_wdata_next    = r_wdata;
        r_cap_rw_next   = r_cap_rw;
        r_cap_da_next   = r_cap_da;
        r_cap_md_next   = r_cap_md;
        r_cap_vxn_next  = r_cap_vxn;
        r_rw_out_next   = r_rw_out;
        r_da_out_next   = r_da_out;
        r_md_out_next   = r_md_out;
        r_f_out_next    = r_f_out;
        r_data_out_next = r_data_out;
        r_vxn_out_next  = r_vxn_out;

        case (r_state)
            S_IDLE: begin
                if (w_mem_op) begin
                    // Capture the instruction; F doubles as the held memory address.
                    r_state_next   = S_WAIT;
                    r_cnt_next     = 8'd0;
                    r_req_next     = 1'b1;
                    r_we_next      = MW;
                    r_addr_next    = F;
                    r_wdata_next   = B_DATA;
                    r_cap_rw_next  = RW;
                    r_cap_da_next  = DA;
                    r_cap_md_next  = MD;
                    r_cap_vxn_next = w_vxn;
                    r_rw_out_next  = 1'b0;
                end else begin
                    r_rw_out_next   = RW;
                    r_da_out_next   = DA;
                    r_md_out_next   = MD;
                    r_f_out_next    = F;
                    r_vxn_out_next  = w_vxn;
                    r_data_out_next = 32'd0;
                end
            end
            S_WAIT: begin
                r_rw_out_next = 1'b0;
                if (MEM_ACK) begin
                    r_state_next    = S_IDLE;
                    r_req_next      = 1'b0;
                    r_rw_out_next   = r_cap_rw;
                    r_da_out_next   = r_cap_da;
                    r_md_out_next   = r_cap_md;
                    r_f_out_next    = r_addr;
                    r_vxn_out_next  = r_cap_vxn;
                    r_data_out_next = w_is_load ? MEM_RDATA : 32'd0;
                end else begin
                    r_cnt_next = w_cnt_inc;
                    if (w_timeout) begin
                        // Abandon the access: release the slot without a register write.
                        r_state_next    = S_IDLE;
                        r_err_next      = 1'b1;
                        r_req_next      = 1'b0;
                        r_da_out_next   = r_cap_da;
                        r_md_out_next   = r_cap_md;
                        r_f_out_next    = r_addr;
                        r_vxn_out_next  = r_cap_vxn;
                        r_data_out_next = 32'd0;
                    end
                end
            end
            default: r_state_next = S_IDLE;
        endcase
    end

    assign RW_out    = r_rw_out;
    assign DA_out    = r_da_out;
    assign MD_out    = r_md_out;
    assign F_out     = r_f_out;
    assign Data_out  = r_data_out;
    assign VxorN_out = r_vxn_out;
    assign MEM_REQ   = r_req;
    assign MEM_WE    = r_we;
    assign MEM_ADDR  = r_addr;
    assign MEM_WDATA = r_wdata;
    assign STALL     = (r_state == S_WAIT);
    assign ERR       = r_err;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, load/store handshakes,
// timeout and asynchronous reset, all against hand-computed values.
module tb_mem_stage;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b0;
    logic        RW = 1'b0;
    logic [4:0]  DA = '0;
    logic [1:0]  MD = '0;
    logic        MW = 1'b0;
    logic [31:0] F = '0;
    logic [31:0] B_DATA = '0;
    logic        V = 1'b0;
    logic        N = 1'b0;
    logic [31:0] MEM_RDATA = '0;
    logic        MEM_ACK = 1'b0;
    logic        RW_out;
    logic [4:0]  DA_out;
    logic [1:0]  MD_out;
    logic [31:0] F_out;
    logic [31:0] Data_out;
    logic        VxorN_out;
    logic        MEM_REQ;
    logic        MEM_WE;
    logic [31:0] MEM_ADDR;
    logic [31:0] MEM_WDATA;
    logic        STALL;
    logic        ERR;

    int n_total = 0;
    int n_bad   = 0;

    mem_stage #(.TIMEOUT(15)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .RW(RW), .DA(DA), .MD(MD), .MW(MW),
        .F(F), .B_DATA(B_DATA), .V(V), .N(N),
        .RW_out(RW_out), .DA_out(DA_out), .MD_out(MD_out), .F_out(F_out),
        .Data_out(Data_out), .VxorN_out(VxorN_out),
        .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
        .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA), .MEM_ACK(MEM_ACK),
        .STALL(STALL), .ERR(ERR)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%08h", tag, got);
        end
    endtask

    // One falling (active) edge, returning on the following rising edge.
    task automatic tick();
        @(negedge CLOCK);
        @(posedge CLOCK);
    endtask

    task automatic drive(input logic rw, input logic [4:0] da, input logic [1:0] md,
                         input logic mw, input logic [31:0] f, input logic [31:0] b,
                         input logic v, input logic n);
        RW = rw; DA = da; MD = md; MW = mw; F = f; B_DATA = b; V = v; N = n;
    endtask

    initial begin
        // Reset state
        #12;
        check_val("rst_rw_out", RW_out, 0);
        check_val("rst_mem_req", MEM_REQ, 0);
        check_val("rst_stall", STALL, 0);
        check_val("rst_err", ERR, 0);
        check_val("rst_addr", MEM_ADDR, 0);
        @(posedge CLOCK);
        RESET = 1'b1;

        // ALU op
        drive(1, 7, 0, 0, 32'h1234, 0, 0, 0);
        tick();
        check_val("alu_rw_out", RW_out, 1);
        check_val("alu_da_out", DA_out, 7);
        check_val("alu_f_out", F_out, 32'h1234);
        check_val("alu_stall", STALL, 0);
        check_val("alu_mem_req", MEM_REQ, 0);
        check_val("alu_data_out", Data_out, 0);

        // V^N select, with a stray ACK in IDLE
        drive(1, 3, 2, 0, 32'h5, 0, 1, 0);
        MEM_ACK = 1'b1; MEM_RDATA = 32'hCAFE0000;
        tick();
        MEM_ACK = 1'b0;
        check_val("vxn_out", VxorN_out, 1);
        check_val("vxn_md_out", MD_out, 2);
        check_val("idle_ack_stall", STALL, 0);
        check_val("idle_ack_data", Data_out, 0);

        // Load, ACK on the third WAIT edge
        drive(1, 9, 1, 0, 32'h40, 32'h77, 0, 0);
        tick();
        check_val("ld_stall0", STALL, 1);
        check_val("ld_req", MEM_REQ, 1);
        check_val("ld_addr", MEM_ADDR, 32'h40);
        check_val("ld_we", MEM_WE, 0);
        check_val("ld_bubble", RW_out, 0);
        drive(0, 1, 0, 1, 32'hFFFF, 32'h1, 0, 0);
        tick();
        check_val("ld_stall1", STALL, 1);
        tick();
        check_val("ld_stall2", STALL, 1);
        check_val("ld_addr_hold", MEM_ADDR, 32'h40);
        check_val("ld_rw_hold", RW_out, 0);
        MEM_ACK = 1'b1; MEM_RDATA = 32'hDEADBEEF;
        tick();
        MEM_ACK = 1'b0;
        check_val("ld_data", Data_out, 32'hDEADBEEF);
        check_val("ld_rw_out", RW_out, 1);
        check_val("ld_da_out", DA_out, 9);
        check_val("ld_stall_end", STALL, 0);
        check_val("ld_req_end", MEM_REQ, 0);

        // Store with MD==1 and MW==1, immediate ACK
        drive(1, 4, 1, 1, 32'h80, 32'h55, 0, 0);
        tick();
        check_val("st_we", MEM_WE, 1);
        check_val("st_wdata", MEM_WDATA, 32'h55);
        check_val("st_addr", MEM_ADDR, 32'h80);
        check_val("st_stall", STALL, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        MEM_ACK = 1'b1; MEM_RDATA = 32'h12345678;
        tick();
        MEM_ACK = 1'b0;
        check_val("st_rw_out", RW_out, 1);
        check_val("st_data", Data_out, 0);
        check_val("st_da_out", DA_out, 4);
        check_val("st_req_end", MEM_REQ, 0);

        // Load with ACK exactly on the 15th WAIT edge
        drive(1, 12, 1, 0, 32'h100, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 14; i++) tick();
        check_val("ack15_stall14", STALL, 1);
        MEM_ACK = 1'b1; MEM_RDATA = 32'hA5A5A5A5;
        tick();
        MEM_ACK = 1'b0;
        check_val("ack15_rw_out", RW_out, 1);
        check_val("ack15_data", Data_out, 32'hA5A5A5A5);
        check_val("ack15_err", ERR, 0);
        check_val("ack15_stall", STALL, 0);

        // Load with no ACK: times out after 15 WAIT edges
        drive(1, 13, 1, 0, 32'h200, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 14; i++) tick();
        check_val("to_stall14", STALL, 1);
        check_val("to_err14", ERR, 0);
        tick();
        check_val("to_err", ERR, 1);
        check_val("to_req", MEM_REQ, 0);
        check_val("to_rw_out", RW_out, 0);
        check_val("to_stall", STALL, 0);
        check_val("to_data", Data_out, 0);
        drive(1, 5, 0, 0, 32'h9, 0, 0, 0);
        tick();
        check_val("to_err_sticky", ERR, 1);
        check_val("to_next_rw", RW_out, 1);

        // Reset asserted mid-WAIT, then a late ACK
        drive(1, 14, 1, 0, 32'h300, 0, 0, 0);
        tick();
        check_val("rw_stall", STALL, 1);
        #2;
        RESET = 1'b0;
        #1;
        check_val("arst_req", MEM_REQ, 0);
        check_val("arst_stall", STALL, 0);
        check_val("arst_err", ERR, 0);
        check_val("arst_addr", MEM_ADDR, 0);
        check_val("arst_f_out", F_out, 0);
        check_val("arst_da_out", DA_out, 0);
        @(posedge CLOCK);
        RESET = 1'b1;
        drive(1, 2, 0, 0, 32'h9, 0, 0, 0);
        MEM_ACK = 1'b1; MEM_RDATA = 32'h00000BAD;
        tick();
        MEM_ACK = 1'b0;
        check_val("late_ack_data", Data_out, 0);
        check_val("late_ack_rw", RW_out, 1);
        check_val("late_ack_da", DA_out, 2);
        check_val("late_ack_stall", STALL, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter TIMEOUT, default 15, meaning: maximum falling edges spent waiting for MEM_ACK before the access is abandoned (range 1..255).
REQ-002 CLOCK  input  1  stage clock; all state updates on the falling edge.
REQ-003 RESET  input  1  asynchronous, active-low reset.
REQ-004 RW  input  1  register-write enable from EX.
REQ-005 DA  input  5  destination register address from EX.
REQ-006 MD  input  2  WB mux select from EX: 0 ALU result, 1 load data, 2 V^N flag, 3 reserved (treated as 0).
REQ-007 MW  input  1  memory-write (store) enable from EX.
REQ-008 F  input  32  ALU result; memory address when MD==1 or MW==1.
REQ-009 B_DATA  input  32  store data from EX.
REQ-010 V, N  input  1 each  overflow and negative flags from EX.
REQ-011 RW_out, DA_out(5), MD_out(2)  output  registered control to WB.
REQ-012 F_out(32), Data_out(32), VxorN_out(1)  output  registered datapath to WB.
REQ-013 MEM_REQ  output  1  data-memory request, level-held until acknowledged.
REQ-014 MEM_WE(1), MEM_ADDR(32), MEM_WDATA(32)  output  memory command, stable while MEM_REQ=1.
REQ-015 MEM_RDATA  input  32  read data, valid in the cycle MEM_ACK=1.
REQ-016 MEM_ACK  input  1  memory completion strobe, one cycle.
REQ-017 STALL  output  1  upstream pipeline hold request.
REQ-018 ERR  output  1  sticky memory-timeout flag.

Function
REQ-019 The block SHALL implement a two-state FSM: IDLE and WAIT.
REQ-020 IDLE, no memory op (MD!=1 and MW==0): each falling edge SHALL register RW, DA, MD, F, V^N into the *_out ports and set Data_out=0; latency one edge.
REQ-021 IDLE, memory op (MD==1 or MW==1): SHALL capture RW, DA, MD, F, V^N, B_DATA, MW internally, assert MEM_REQ with MEM_ADDR=F, MEM_WE=MW, MEM_WDATA=B_DATA, drive RW_out=0 (bubble), zero the wait counter, and enter WAIT.
REQ-022 MD==1 and MW==1 together SHALL be treated as a store (MEM_WE=1); Data_out SHALL return 0.
REQ-023 STALL SHALL equal 1 exactly while state==WAIT; EX inputs SHALL be ignored in WAIT.
REQ-024 WAIT: RW_out SHALL stay 0 and MEM_REQ/MEM_WE/MEM_ADDR/MEM_WDATA SHALL stay constant.
REQ-025 WAIT with MEM_ACK=1 at a falling edge: SHALL drive the captured control/F/VxorN to outputs, Data_out=MEM_RDATA for loads (0 for stores), deassert MEM_REQ, return to IDLE.
REQ-026 WAIT without MEM_ACK: counter SHALL increment; when it reaches TIMEOUT the block SHALL set ERR=1, deassert MEM_REQ, release the captured instruction with RW_out=0 and Data_out=0, return to IDLE.
REQ-027 MEM_ACK arriving on the same edge as the timeout SHALL win (normal completion, ERR unchanged).
REQ-028 MEM_ACK while IDLE SHALL be ignored.
REQ-029 After return to IDLE, STALL SHALL be 0 and the next EX instruction SHALL be accepted on the following falling edge; back-to-back memory ops SHALL each incur their own WAIT.
REQ-030 ERR SHALL remain 1 until reset.

Reset
REQ-031 RESET low SHALL immediately force IDLE, counter=0, ERR=0, MEM_REQ=0, MEM_WE=0, STALL=0, and every *_out, MEM_ADDR, MEM_WDATA to 0, independent of CLOCK.
REQ-032 RESET asserted in WAIT SHALL abandon the outstanding access with no write-back; a late MEM_ACK after release SHALL be ignored.
REQ-033 First capture SHALL occur on the first falling edge after RESET returns high.

Verification
REQ-034 ALU op RW=1, DA=7, MD=0, F=0x1234 -> next edge RW_out=1, DA_out=7, F_out=0x1234, STALL=0, MEM_REQ=0.
REQ-035 Load MD=1, F=0x40, ACK after 3 edges with RDATA=0xDEADBEEF -> STALL=1 for 3 edges, MEM_ADDR=0x40, MEM_WE=0, then Data_out=0xDEADBEEF, RW_out=1.
REQ-036 Store MW=1, F=0x80, B_DATA=0x55, immediate ACK -> MEM_WE=1, MEM_WDATA=0x55 one WAIT edge, then RW_out=captured RW, Data_out=0.
REQ-037 Load with no ACK, TIMEOUT=15 -> after 15 WAIT edges ERR=1, MEM_REQ=0, RW_out=0, STALL=0; ACK on the 15th edge instead -> normal completion, ERR=0.
REQ-038 MD=2, V=1, N=0 -> VxorN_out=1; RESET low mid-WAIT -> all outputs 0 asynchronously, later ACK ignored.
